// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//   Memory-mapped countdown timer that raises the hardware interrupt for the
//   pipelined MIPS core. Software programs it through the CPU bridge (Timer0 at
//   0x7F00, Timer1 at 0x7F10); only addr[3:2] is decoded here.
//
//   Register map (addr[3:2]):
//     00 CTRL   R/W  [0] EN, [2:1] MODE (01 auto-reload, else one-shot), [3] IM
//     01 PRESET R/W  low CNT_W bits stored
//     10 COUNT  RO   current count
//     11 --     reads 0, writes ignored
//
// Ports
//   clk    in   1   system clock, all state on posedge
//   reset  in   1   asynchronous active-low reset (0 = reset)
//   addr   in   32  byte address from the bridge
//   we     in   1   write strobe for the register at addr
//   din    in   32  write data
//   dout   out  32  combinational read data for addr
//   irq    out  1   interrupt request = CTRL.IM & irq_flag
// -----------------------------------------------------------------------------
module timer_counter #(
   parameter int unsigned          CNT_W      = 32,
   parameter logic [CNT_W-1:0]     PRESET_RST = '0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_CNT  = 2'b10,
      ST_INT  = 2'b11
   } state_t;

   state_t           state_q,  state_d;
   logic [3:0]       ctrl_q,   ctrl_d;
   logic [CNT_W-1:0] preset_q, preset_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             flag_q,   flag_d;
   logic             irq_q,    irq_d;

   logic             wr_ctrl_s;
   logic             wr_preset_s;
   logic             auto_reload_s;
   logic             flag_set_s;
   logic             flag_rel_s;
   logic             en_clr_s;
   logic             unused_bits_s;

   // Only addr[3:2] and the low CTRL/PRESET bits of din carry meaning.
   assign unused_bits_s = ^{addr[31:4], addr[1:0], din[31:4]};

   assign wr_ctrl_s     = we && (addr[3:2] == 2'b00);
   assign wr_preset_s   = we && (addr[3:2] == 2'b01);
   assign auto_reload_s = (ctrl_q[2:1] == 2'b01);

   // FSM next state, COUNT update and the flag/EN side effects of each state.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      flag_set_s = 1'b0;
      flag_rel_s = 1'b0;
      en_clr_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_q[0]) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_q[0]) begin
               // Paused: COUNT stays frozen so software can read it.
               state_d = ST_IDLE;
            end else if (count_q > CNT_ONE) begin
               count_d = count_q - CNT_ONE;
               state_d = ST_CNT;
            end else begin
               // COUNT of 0 or 1 expires here, so it never wraps below zero.
               count_d    = CNT_ZERO;
               flag_set_s = 1'b1;
               state_d    = ST_INT;
            end
         end
         ST_INT: begin
            if (auto_reload_s) begin
               flag_rel_s = 1'b1;
               state_d    = ST_LOAD;
            end else begin
               en_clr_s = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // CTRL update: a same-edge software write beats the one-shot EN clear.
   always_comb begin
      ctrl_d = ctrl_q;
      if (wr_ctrl_s) begin
         ctrl_d = din[3:0];
      end else if (en_clr_s) begin
         ctrl_d = {ctrl_q[3:1], 1'b0};
      end else begin
         ctrl_d = ctrl_q;
      end
   end

   // PRESET update; a running COUNT only picks it up at the next LOAD.
   always_comb begin
      preset_d = preset_q;
      if (wr_preset_s) begin
         preset_d = din[CNT_W-1:0];
      end else begin
         preset_d = preset_q;
      end
   end

   // Interrupt flag: expiry set outranks the CTRL-write clear so no event is lost.
   always_comb begin
      flag_d = flag_q;
      if (flag_set_s) begin
         flag_d = 1'b1;
      end else if (wr_ctrl_s || flag_rel_s) begin
         flag_d = 1'b0;
      end else begin
         flag_d = flag_q;
      end
      irq_d = ctrl_d[3] & flag_d;
   end

   // Read mux; PRESET and COUNT are zero-extended to the bus width.
   always_comb begin
      dout = 32'h0000_0000;
      case (addr[3:2])
         2'b00:   dout[3:0]       = ctrl_q;
         2'b01:   dout[CNT_W-1:0] = preset_q;
         2'b10:   dout[CNT_W-1:0] = count_q;
         default: dout            = 32'h0000_0000;
      endcase
   end

   // State registers; irq is a flop loaded with exactly IM & flag of the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         ctrl_q   <= 4'h0;
         preset_q <= PRESET_RST;
         count_q  <= CNT_ZERO;
         flag_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         flag_q   <= flag_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//   Directed bench for timer_counter. The stimulus process drives bus cycles and
//   pushes expected irq/dout values into a scoreboard queue; a monitor on the
//   falling edge pops each entry and compares it with the DUT output.
// -----------------------------------------------------------------------------
module tb_timer_counter;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          is_rd;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];

   timer_counter #(.CNT_W(32), .PRESET_RST(32'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .din   (din),
      .dout  (dout),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every queued expectation is compared at the next falling edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (sb.size() != 0) begin
         e   = sb.pop_front();
         act = e.is_rd ? dout : {31'b0, irq};
         checks++;
         if (act !== e.exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      din  = d;
      we   = 1'b1;
      @(posedge clk);
      #1;
      we   = 1'b0;
      din  = 32'h0;
   endtask

   task automatic chk_irq(input string name, input logic v);
      exp_t e;
      e.is_rd = 1'b0;
      e.exp   = {31'b0, v};
      e.name  = name;
      sb.push_back(e);
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] v);
      exp_t e;
      addr    = a;
      e.is_rd = 1'b1;
      e.exp   = v;
      e.name  = name;
      sb.push_back(e);
      step(1);
   endtask

   initial begin
      reset = 1'b0;
      we    = 1'b0;
      addr  = 32'h0;
      din   = 32'h0;
      @(posedge clk);
      #1;

      // ---- 1: reset values ----
      chk_irq("rst_irq", 1'b0);
      rd_chk("rst_ctrl",   32'h7F00, 32'h0);
      rd_chk("rst_preset", 32'h7F04, 32'h0);
      rd_chk("rst_count",  32'h7F08, 32'h0);
      rd_chk("rst_rsvd",   32'h7F0C, 32'h0);
      reset = 1'b1;
      step(2);

      // ---- 2: one-shot, PRESET=5, irq 7 edges after CTRL write ----
      wr(32'h7F04, 32'd5);
      wr(32'h7F00, 32'h9);
      chk_irq("os_irq_t0", 1'b0);
      rd_chk("os_cnt_t0", 32'h7F08, 32'd0);
      chk_irq("os_irq_t1", 1'b0);
      rd_chk("os_cnt_t1", 32'h7F08, 32'd0);
      for (int k = 0; k < 5; k++) begin
         chk_irq($sformatf("os_irq_t%0d", k + 2), 1'b0);
         rd_chk($sformatf("os_cnt_t%0d", k + 2), 32'h7F08, 32'd5 - 32'(k));
      end
      chk_irq("os_irq_t7", 1'b1);
      rd_chk("os_cnt_t7", 32'h7F08, 32'd0);
      chk_irq("os_irq_t8", 1'b1);
      rd_chk("os_ctrl_en0", 32'h7F00, 32'h8);
      step(3);
      chk_irq("os_irq_held", 1'b1);
      wr(32'h7F00, 32'h8);
      chk_irq("os_irq_clr", 1'b0);
      step(2);
      chk_irq("os_irq_clr2", 1'b0);

      // ---- 3: auto-reload, PRESET=3, pulse every 5 cycles ----
      wr(32'h7F04, 32'd3);
      wr(32'h7F00, 32'hB);
      for (int k = 0; k < 26; k++) begin
         chk_irq($sformatf("ar_irq_t%0d", k),
                 (k >= 5) && (((k - 5) % 5) == 0));
         step(1);
      end
      wr(32'h7F00, 32'h0);
      step(3);

      // ---- 4a: masked, flag sets silently; CTRL=0x8 clears it ----
      wr(32'h7F04, 32'd2);
      wr(32'h7F00, 32'h1);
      for (int k = 0; k < 7; k++) begin
         chk_irq($sformatf("mask_irq_t%0d", k), 1'b0);
         step(1);
      end
      rd_chk("mask_ctrl", 32'h7F00, 32'h0);
      wr(32'h7F00, 32'h8);
      chk_irq("mask_clr_irq", 1'b0);
      rd_chk("mask_clr_cnt", 32'h7F08, 32'd0);
      chk_irq("mask_clr_irq2", 1'b0);
      rd_chk("mask_clr_ctrl", 32'h7F00, 32'h8);
      wr(32'h7F00, 32'h0);

      // ---- 4b: pause at COUNT=7, then restart from PRESET ----
      wr(32'h7F04, 32'd9);
      wr(32'h7F00, 32'h1);
      step(3);
      wr(32'h7F00, 32'h0);
      rd_chk("pause_cnt_a", 32'h7F08, 32'd7);
      rd_chk("pause_cnt_b", 32'h7F08, 32'd7);
      step(2);
      rd_chk("pause_cnt_c", 32'h7F08, 32'd7);
      wr(32'h7F00, 32'h1);
      rd_chk("restart_s0", 32'h7F08, 32'd7);
      rd_chk("restart_s1", 32'h7F08, 32'd7);
      rd_chk("restart_s2", 32'h7F08, 32'd9);
      rd_chk("restart_s3", 32'h7F08, 32'd8);
      wr(32'h7F00, 32'h0);
      step(2);

      // ---- 5a: same-edge CTRL write at expiry keeps the flag ----
      wr(32'h7F04, 32'd2);
      wr(32'h7F00, 32'h1);
      step(3);
      wr(32'h7F00, 32'h8);
      chk_irq("same_edge_irq", 1'b1);
      rd_chk("same_edge_ctrl", 32'h7F00, 32'h8);
      chk_irq("same_edge_irq2", 1'b1);
      step(1);
      // Core handler acknowledges through the Timer1 alias with IM=0.
      wr(32'h7F10, 32'h0);
      chk_irq("handler_clr", 1'b0);
      step(1);

      // ---- 5b: writes to COUNT and the reserved slot are ignored ----
      wr(32'h7F08, 32'hFFFF_FFFF);
      wr(32'h7F0C, 32'h0000_0009);
      step(3);
      chk_irq("ign_irq", 1'b0);
      rd_chk("ign_cnt",    32'h7F08, 32'd0);
      rd_chk("ign_preset", 32'h7F04, 32'd2);
      rd_chk("ign_rsvd",   32'h7F0C, 32'd0);
      rd_chk("ign_ctrl",   32'h7F00, 32'h0);

      // ---- 5c: PRESET=0 fires 3 edges after the CTRL write ----
      wr(32'h7F04, 32'd0);
      wr(32'h7F00, 32'h9);
      for (int k = 0; k < 5; k++) begin
         chk_irq($sformatf("p0_irq_t%0d", k), k >= 3);
         step(1);
      end
      // Asynchronous reset drops a held irq without waiting for an edge.
      reset = 1'b0;
      chk_irq("rst_async_irq", 1'b0);
      rd_chk("rst_async_ctrl", 32'h7F00, 32'h0);
      reset = 1'b1;
      step(1);

      // ---- 1b: reset mid-CNT ----
      wr(32'h7F04, 32'd20);
      wr(32'h7F00, 32'h9);
      step(6);
      rd_chk("midcnt_cnt", 32'h7F08, 32'd16);
      reset = 1'b0;
      chk_irq("midcnt_rst_irq", 1'b0);
      rd_chk("midcnt_rst_cnt",    32'h7F08, 32'd0);
      rd_chk("midcnt_rst_ctrl",   32'h7F00, 32'h0);
      rd_chk("midcnt_rst_preset", 32'h7F04, 32'd0);
      reset = 1'b1;
      step(3);
      chk_irq("post_rst_irq", 1'b0);
      rd_chk("post_rst_cnt", 32'h7F08, 32'd0);

      step(2);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
